// File: rtl/laser_share_arbiter.sv
// Round-robin sequencer that shares one laser enable between N front-panel buttons,
// firing for a fixed on-time and enforcing a fixed cool-down after every firing.
module laser_share_arbiter #(
   parameter int N           = 4,
   parameter int ON_CYCLES   = 16,
   parameter int COOL_CYCLES = 8,
   parameter int CW          = 8
) (
   input  logic         Clk,
   input  logic         Rst_n,
   input  logic [N-1:0] B,
   input  logic         Stop,
   output logic         X,
   output logic [N-1:0] Grant,
   output logic [N-1:0] Done,
   output logic         Aborted,
   output logic         Busy
);

   localparam int LW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] ON_LOAD   = CW'(ON_CYCLES - 1);
   localparam logic [CW-1:0] COOL_LOAD = (COOL_CYCLES > 0) ? CW'(COOL_CYCLES - 1) : '0;
   localparam logic [LW-1:0] LAST_RST  = LW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_COOL = 2'd2
   } state_e;

   // With no cool-down configured, a finished or aborted firing returns straight to IDLE.
   localparam state_e AFTER_FIRE = (COOL_CYCLES > 0) ? S_COOL : S_IDLE;

   state_e          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [N-1:0]    pend_q,  pend_d;
   logic [LW-1:0]   last_q,  last_d;
   logic            x_q,     x_d;
   logic [N-1:0]    grant_q, grant_d;
   logic [N-1:0]    done_q,  done_d;
   logic            aborted_q, aborted_d;

   logic            found;
   logic [LW-1:0]   win;
   logic [N-1:0]    win_oh;

   // Round-robin search starting just after the last winner, wrapping modulo N.
   always_comb begin
      int          idx;
      logic [LW-1:0] idx_l;
      found  = 1'b0;
      win    = last_q;
      win_oh = '0;
      for (int off = 1; off <= N; off++) begin
         idx   = (int'(last_q) + off) % N;
         idx_l = LW'(idx);
         if (!found && pend_q[idx_l]) begin
            found         = 1'b1;
            win           = idx_l;
            win_oh[idx_l] = 1'b1;
         end
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves it unassigned,
   // which is what keeps this block from inferring latches.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      pend_d    = pend_q | B;
      last_d    = last_q;
      x_d       = 1'b0;
      grant_d   = '0;
      done_d    = '0;
      aborted_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               x_d     = 1'b1;
               grant_d = win_oh;
               count_d = ON_LOAD;
               pend_d  = pend_d & ~win_oh;
               last_d  = win;
               state_d = S_ON;
            end
         end
         S_ON: begin
            if (Stop) begin
               aborted_d = 1'b1;
               count_d   = COOL_LOAD;
               state_d   = AFTER_FIRE;
            end else if (count_q == '0) begin
               done_d  = grant_q;
               count_d = COOL_LOAD;
               state_d = AFTER_FIRE;
            end else begin
               x_d     = 1'b1;
               grant_d = grant_q;
               count_d = count_q - CW'(1);
            end
         end
         S_COOL: begin
            if (count_q == '0) begin
               state_d = S_IDLE;
            end else begin
               count_d = count_q - CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            count_d = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         pend_q    <= '0;
         last_q    <= LAST_RST;
         x_q       <= 1'b0;
         grant_q   <= '0;
         done_q    <= '0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         pend_q    <= pend_d;
         last_q    <= last_d;
         x_q       <= x_d;
         grant_q   <= grant_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   assign X       = x_q;
   assign Grant   = grant_q;
   assign Done    = done_q;
   assign Aborted = aborted_q;
   assign Busy    = (state_q == S_ON) || (state_q == S_COOL);

endmodule

// File: tb/tb_laser_share_arbiter.sv
// Directed bench for laser_share_arbiter: a cycle table for the rotation scenarios plus
// hand sequences for Stop, cool-down capture, async reset and a 1-clock/no-cool variant.
module tb_laser_share_arbiter;

   localparam int N = 4;

   logic         Clk = 1'b0;
   logic         Rst_n;
   logic [N-1:0] B, B1;
   logic         Stop, Stop1;
   logic         X, X1;
   logic [N-1:0] Grant, Grant1, Done, Done1;
   logic         Aborted, Aborted1, Busy, Busy1;

   always #5 Clk = ~Clk;

   laser_share_arbiter #(.N(N), .ON_CYCLES(16), .COOL_CYCLES(8), .CW(8)) u_dut (
      .Clk(Clk), .Rst_n(Rst_n), .B(B), .Stop(Stop),
      .X(X), .Grant(Grant), .Done(Done), .Aborted(Aborted), .Busy(Busy)
   );

   laser_share_arbiter #(.N(N), .ON_CYCLES(1), .COOL_CYCLES(0), .CW(8)) u_dut1 (
      .Clk(Clk), .Rst_n(Rst_n), .B(B1), .Stop(Stop1),
      .X(X1), .Grant(Grant1), .Done(Done1), .Aborted(Aborted1), .Busy(Busy1)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic x, input logic [3:0] g,
                            input logic [3:0] d, input logic a, input logic busy);
      check({tag, ".X"},       X,       x);
      check({tag, ".Grant"},   Grant,   g);
      check({tag, ".Done"},    Done,    d);
      check({tag, ".Aborted"}, Aborted, a);
      check({tag, ".Busy"},    Busy,    busy);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   typedef struct {
      logic       rst_n;
      logic [3:0] b;
      logic       stop;
      int         reps;
      logic       x;
      logic [3:0] grant;
      logic [3:0] done;
      logic       aborted;
      logic       busy;
   } row_t;

   row_t tbl[$];

   function automatic void add(input logic r, input logic [3:0] b, input logic s, input int reps,
                               input logic x, input logic [3:0] g, input logic [3:0] d,
                               input logic a, input logic busy);
      row_t t;
      t.rst_n = r; t.b = b; t.stop = s; t.reps = reps;
      t.x = x; t.grant = g; t.done = d; t.aborted = a; t.busy = busy;
      tbl.push_back(t);
   endfunction

   // One complete firing: 16 on, Done pulse at the fall, 7 more COOL edges, then IDLE.
   function automatic void add_firing(input logic [3:0] g, input logic [3:0] bh);
      add(1'b1, bh, 1'b0, 16, 1'b1, g,    4'b0, 1'b0, 1'b1);
      add(1'b1, bh, 1'b0, 1,  1'b0, 4'b0, g,    1'b0, 1'b1);
      add(1'b1, bh, 1'b0, 7,  1'b0, 4'b0, 4'b0, 1'b0, 1'b1);
      add(1'b1, bh, 1'b0, 1,  1'b0, 4'b0, 4'b0, 1'b0, 1'b0);
   endfunction

   function automatic void add_idle(input logic r, input logic [3:0] b, input logic s, input int reps);
      add(r, b, s, reps, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      Rst_n = 1'b0; B = '0; Stop = 1'b0; B1 = '0; Stop1 = 1'b0;

      // Single button, then full rotation, then rotation from Last=2, then a held pair.
      add_idle(1'b0, 4'b0000, 1'b0, 1);
      add_idle(1'b1, 4'b0001, 1'b0, 1);
      add_firing(4'b0001, 4'b0000);
      add_idle(1'b1, 4'b0000, 1'b1, 2);
      add_idle(1'b0, 4'b0000, 1'b0, 1);
      add_idle(1'b1, 4'b1111, 1'b0, 1);
      for (int r = 0; r < N; r++) add_firing(4'(1 << r), 4'b0000);
      add_idle(1'b1, 4'b0000, 1'b0, 2);
      add_idle(1'b0, 4'b0000, 1'b0, 1);
      add_idle(1'b1, 4'b0100, 1'b0, 1);
      add_firing(4'b0100, 4'b0000);
      add_idle(1'b1, 4'b0101, 1'b0, 1);
      add_firing(4'b0001, 4'b0000);
      add_firing(4'b0100, 4'b0000);
      add_idle(1'b1, 4'b0000, 1'b0, 2);
      add_idle(1'b0, 4'b0000, 1'b0, 1);
      add_idle(1'b1, 4'b0011, 1'b0, 1);
      add_firing(4'b0001, 4'b0011);
      add_firing(4'b0010, 4'b0011);
      add_firing(4'b0001, 4'b0000);
      add_idle(1'b0, 4'b0000, 1'b0, 1);

      #1;
      check_all("reset", 1'b0, 4'b0, 4'b0, 1'b0, 1'b0);

      foreach (tbl[i]) begin
         Rst_n = tbl[i].rst_n;
         B     = tbl[i].b;
         Stop  = tbl[i].stop;
         for (int k = 0; k < tbl[i].reps; k++) begin
            tick();
            check_all($sformatf("row%0d.%0d", i, k), tbl[i].x, tbl[i].grant,
                      tbl[i].done, tbl[i].aborted, tbl[i].busy);
         end
      end

      // Stop on the 5th ON clock, Stop/B[1] during COOL, then Stop racing Count==0.
      Rst_n = 1'b1; B = 4'b0001; Stop = 1'b0;
      tick();
      B = 4'b0000;
      tick();
      check_all("stop.rise", 1'b1, 4'b0001, 4'b0, 1'b0, 1'b1);
      repeat (4) tick();
      check("stop.on5.X", X, 1'b1);
      Stop = 1'b1;
      tick();
      check_all("stop.abort", 1'b0, 4'b0, 4'b0, 1'b1, 1'b1);
      Stop = 1'b1; B = 4'b0010;
      tick();
      check_all("stop.cool_ignored", 1'b0, 4'b0, 4'b0, 1'b0, 1'b1);
      Stop = 1'b0; B = 4'b0000;
      for (int k = 0; k < 6; k++) begin
         tick();
         check_all($sformatf("stop.cool%0d", k), 1'b0, 4'b0, 4'b0, 1'b0, 1'b1);
      end
      tick();
      check_all("stop.idle", 1'b0, 4'b0, 4'b0, 1'b0, 1'b0);
      tick();
      check_all("cool_capture.rise", 1'b1, 4'b0010, 4'b0, 1'b0, 1'b1);
      repeat (15) tick();
      check("last_on.X", X, 1'b1);
      Stop = 1'b1;
      tick();
      check_all("stop_vs_done", 1'b0, 4'b0, 4'b0, 1'b1, 1'b1);
      Stop = 1'b0;
      tick();
      check("stop_vs_done.pulse_end", Aborted, 1'b0);

      // Asynchronous reset between edges during ON; the queued request must vanish.
      Rst_n = 1'b0;
      tick();
      Rst_n = 1'b1; B = 4'b0011;
      tick();
      B = 4'b0000;
      tick();
      check_all("arst.rise", 1'b1, 4'b0001, 4'b0, 1'b0, 1'b1);
      repeat (3) tick();
      #3 Rst_n = 1'b0;
      #1;
      check_all("arst.immediate", 1'b0, 4'b0, 4'b0, 1'b0, 1'b0);
      #2 Rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check_all($sformatf("arst.pend_lost%0d", k), 1'b0, 4'b0, 4'b0, 1'b0, 1'b0);
      end

      // One-clock firing with no cool-down: X high 1 clock, 1 IDLE clock between owners.
      B1 = 4'b0011;
      tick();
      check("on1.capture.X", X1, 1'b0);
      B1 = 4'b0000;
      tick();
      check("on1.fire0.X", X1, 1'b1);
      check("on1.fire0.Grant", Grant1, 4'b0001);
      tick();
      check("on1.done0.X", X1, 1'b0);
      check("on1.done0.Done", Done1, 4'b0001);
      check("on1.done0.Busy", Busy1, 1'b0);
      tick();
      check("on1.fire1.X", X1, 1'b1);
      check("on1.fire1.Grant", Grant1, 4'b0010);
      tick();
      check("on1.done1.Done", Done1, 4'b0010);
      check("on1.done1.X", X1, 1'b0);
      tick();
      check("on1.idle.Done", Done1, 4'b0000);
      check("on1.idle.X", X1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
